// File: rtl/pipelined_multiplier_if.sv
// Request/result bundle for the pipelined multiplier.
// The master issues operations and consumes results.
interface pipelined_multiplier_if #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 5
);
    logic                 flush;
    logic                 multiplierStart;
    logic                 multiplierReady;
    logic                 signA;
    logic                 signB;
    logic [WIDTH-1:0]     operandA;
    logic [WIDTH-1:0]     operandB;
    logic [TAG_WIDTH-1:0] tagIn;
    logic [WIDTH-1:0]     multiplierResultHigh;
    logic [WIDTH-1:0]     multiplierResultLow;
    logic                 multiplierDone;
    logic [TAG_WIDTH-1:0] tagOut;
    logic                 resultAccept;

    modport master (
        output flush, multiplierStart, signA, signB,
        output operandA, operandB, tagIn, resultAccept,
        input  multiplierReady, multiplierResultHigh,
        input  multiplierResultLow, multiplierDone, tagOut
    );

    modport slave (
        input  flush, multiplierStart, signA, signB,
        input  operandA, operandB, tagIn, resultAccept,
        output multiplierReady, multiplierResultHigh,
        output multiplierResultLow, multiplierDone, tagOut
    );
endinterface

// File: rtl/pipelined_multiplier.sv
// Fully pipelined WIDTHxWIDTH multiplier with tag sideband,
// per-operand signedness, whole-pipe backpressure and flush.
module pipelined_multiplier #(
    parameter int WIDTH     = 32,
    parameter int STAGES    = 3,
    parameter int TAG_WIDTH = 5
) (
    input logic                   clk,
    input logic                   reset,
    pipelined_multiplier_if.slave bus
);
    localparam int PW = 2 * WIDTH;

    logic [STAGES-1:0]    vld;
    logic [TAG_WIDTH-1:0] tg [STAGES];
    logic [PW-1:0]        pr [STAGES];
    logic [WIDTH-1:0]     opA;
    logic [WIDTH-1:0]     opB;
    logic                 sA;
    logic                 sB;
    logic                 stall;
    logic                 ready;
    logic                 accept;

    // Extending to 2*WIDTH keeps the low 2*WIDTH product bits exact.
    function automatic logic [PW-1:0] mulx(
        input logic             sa,
        input logic             sb,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [PW-1:0] ea;
        logic [PW-1:0] eb;
        ea = {{WIDTH{sa & a[WIDTH-1]}}, a};
        eb = {{WIDTH{sb & b[WIDTH-1]}}, b};
        return ea * eb;
    endfunction

    assign stall  = vld[STAGES-1] & ~bus.resultAccept;
    assign ready  = ~reset & ~bus.flush & (~stall | ~vld[0]);
    assign accept = bus.multiplierStart & ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            opA <= '0;
            opB <= '0;
            sA  <= 1'b0;
            sB  <= 1'b0;
            for (int i = 0; i < STAGES; i++) begin
                tg[i] <= '0;
                pr[i] <= '0;
            end
        end else if (bus.flush) begin
            vld <= '0;
        end else begin
            // Slot 0 may fill a bubble even while the rest is stalled.
            if (ready) begin
                vld[0] <= accept;
                if (accept) begin
                    tg[0] <= bus.tagIn;
                    opA   <= bus.operandA;
                    opB   <= bus.operandB;
                    sA    <= bus.signA;
                    sB    <= bus.signB;
                    if (STAGES == 1) begin
                        pr[0] <= mulx(bus.signA, bus.signB,
                                      bus.operandA, bus.operandB);
                    end
                end
            end
            if (!stall) begin
                for (int i = 1; i < STAGES; i++) begin
                    vld[i] <= vld[i-1];
                    if (vld[i-1]) begin
                        tg[i] <= tg[i-1];
                        if (i == 1) begin
                            pr[i] <= mulx(sA, sB, opA, opB);
                        end else begin
                            pr[i] <= pr[i-1];
                        end
                    end
                end
            end
        end
    end

    assign bus.multiplierReady      = ready;
    assign bus.multiplierDone       = vld[STAGES-1];
    assign bus.tagOut               = tg[STAGES-1];
    assign bus.multiplierResultHigh = pr[STAGES-1][PW-1:WIDTH];
    assign bus.multiplierResultLow  = pr[STAGES-1][WIDTH-1:0];
endmodule

// File: tb/tb_pipelined_multiplier.sv
// Directed bench for pipelined_multiplier (32-bit, 3 stages, 5-bit tag).
module tb_pipelined_multiplier;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipelined_multiplier_if #(.WIDTH(32), .TAG_WIDTH(5)) bus ();

    pipelined_multiplier #(
        .WIDTH(32), .STAGES(3), .TAG_WIDTH(5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic        vs [4];
    logic [31:0] vh [4];
    logic [31:0] vl [4];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic sa, input logic sb,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t);
        bus.multiplierStart = 1'b1;
        bus.signA = sa;
        bus.signB = sb;
        bus.operandA = a;
        bus.operandB = b;
        bus.tagIn = t;
    endtask

    task automatic run_one(input string nm, input logic sa, input logic sb,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] t, input logic [31:0] eh,
                           input logic [31:0] el);
        set_op(sa, sb, a, b, t);
        #1;
        chk({nm, "_ready"}, 64'(bus.multiplierReady), 64'd1);
        step();
        bus.multiplierStart = 1'b0;
        chk({nm, "_done_c1"}, 64'(bus.multiplierDone), 64'd0);
        step();
        chk({nm, "_done_c2"}, 64'(bus.multiplierDone), 64'd0);
        step();
        chk({nm, "_done"}, 64'(bus.multiplierDone), 64'd1);
        chk({nm, "_hi"}, 64'(bus.multiplierResultHigh), 64'(eh));
        chk({nm, "_lo"}, 64'(bus.multiplierResultLow), 64'(el));
        chk({nm, "_tag"}, 64'(bus.tagOut), 64'(t));
        step();
        chk({nm, "_pulse"}, 64'(bus.multiplierDone), 64'd0);
    endtask

    initial begin
        int k;
        int r;
        va[0] = 32'd3;        vb[0] = 32'd5;
        vs[0] = 1'b0;         vh[0] = 32'h0;        vl[0] = 32'd15;
        va[1] = 32'h80000000; vb[1] = 32'd4;
        vs[1] = 1'b0;         vh[1] = 32'h2;        vl[1] = 32'h0;
        va[2] = 32'h12345678; vb[2] = 32'h10;
        vs[2] = 1'b0;         vh[2] = 32'h1;        vl[2] = 32'h23456780;
        va[3] = 32'hFFFFFFFF; vb[3] = 32'hFFFFFFFF;
        vs[3] = 1'b1;         vh[3] = 32'h0;        vl[3] = 32'h1;

        bus.flush = 1'b0;
        bus.multiplierStart = 1'b0;
        bus.signA = 1'b0;
        bus.signB = 1'b0;
        bus.operandA = '0;
        bus.operandB = '0;
        bus.tagIn = '0;
        bus.resultAccept = 1'b1;

        step();
        step();
        chk("rst_ready", 64'(bus.multiplierReady), 64'd0);
        chk("rst_done", 64'(bus.multiplierDone), 64'd0);
        chk("rst_hi", 64'(bus.multiplierResultHigh), 64'd0);
        chk("rst_lo", 64'(bus.multiplierResultLow), 64'd0);
        chk("rst_tag", 64'(bus.tagOut), 64'd0);
        reset = 1'b0;
        #1;
        chk("rel_ready", 64'(bus.multiplierReady), 64'd1);
        step();

        run_one("uu_max", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,
                32'hFFFFFFFE, 32'h00000001);
        run_one("ss", 1'b1, 1'b1, 32'hFFFFFFFF, 32'h2, 5'd1,
                32'hFFFFFFFF, 32'hFFFFFFFE);
        run_one("su", 1'b1, 1'b0, 32'hFFFFFFFF, 32'h2, 5'd2,
                32'hFFFFFFFF, 32'hFFFFFFFE);
        run_one("uu", 1'b0, 1'b0, 32'hFFFFFFFF, 32'h2, 5'd3,
                32'h00000001, 32'hFFFFFFFE);
        run_one("us", 1'b0, 1'b1, 32'h2, 32'h80000000, 5'd4,
                32'hFFFFFFFF, 32'h00000000);

        // Back-to-back issue, results stream out three cycles later.
        for (int c = 0; c < 6; c++) begin
            if (c < 4) set_op(vs[c], vs[c], va[c], vb[c], 5'(c));
            else bus.multiplierStart = 1'b0;
            step();
            if (c >= 2) begin
                chk("b2b_done", 64'(bus.multiplierDone), 64'd1);
                chk("b2b_hi", 64'(bus.multiplierResultHigh), 64'(vh[c-2]));
                chk("b2b_lo", 64'(bus.multiplierResultLow), 64'(vl[c-2]));
                chk("b2b_tag", 64'(bus.tagOut), 64'(c-2));
            end
        end
        step();
        chk("b2b_end", 64'(bus.multiplierDone), 64'd0);

        // Backpressure: consumer stalls until cycle 8.
        bus.resultAccept = 1'b0;
        k = 0;
        r = 0;
        for (int c = 0; c < 30 && r < 4; c++) begin
            logic acc;
            logic take;
            if (c == 8) bus.resultAccept = 1'b1;
            if (k < 4) set_op(vs[k], vs[k], va[k], vb[k], 5'(8 + k));
            else bus.multiplierStart = 1'b0;
            #1;
            acc = bus.multiplierStart & bus.multiplierReady;
            take = bus.multiplierDone & bus.resultAccept;
            if (c >= 3 && c < 8) begin
                chk("bp_ready", 64'(bus.multiplierReady), 64'd0);
                chk("bp_hold_done", 64'(bus.multiplierDone), 64'd1);
                chk("bp_hold_lo", 64'(bus.multiplierResultLow), 64'(vl[0]));
                chk("bp_hold_tag", 64'(bus.tagOut), 64'd8);
            end
            if (take) begin
                chk("bp_hi", 64'(bus.multiplierResultHigh), 64'(vh[r]));
                chk("bp_lo", 64'(bus.multiplierResultLow), 64'(vl[r]));
                chk("bp_tag", 64'(bus.tagOut), 64'(8 + r));
                r++;
            end
            @(posedge clk);
            #1;
            if (acc) k++;
        end
        bus.multiplierStart = 1'b0;
        chk("bp_issued", 64'(k), 64'd4);
        chk("bp_received", 64'(r), 64'd4);
        chk("bp_no_dup", 64'(bus.multiplierDone), 64'd0);

        // Flush with two ops in flight and a start in the flush cycle.
        set_op(1'b0, 1'b0, 32'd9, 32'd9, 5'd10);
        step();
        set_op(1'b0, 1'b0, 32'd8, 32'd8, 5'd11);
        step();
        set_op(1'b0, 1'b0, 32'd7, 32'd7, 5'd12);
        bus.flush = 1'b1;
        #1;
        chk("fl_ready", 64'(bus.multiplierReady), 64'd0);
        step();
        bus.flush = 1'b0;
        bus.multiplierStart = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("fl_no_done", 64'(bus.multiplierDone), 64'd0);
            step();
        end
        run_one("fl_next", 1'b0, 1'b0, 32'd3, 32'd5, 5'd13, 32'd0, 32'd15);

        // Async reset while a result is on the outputs.
        set_op(1'b0, 1'b0, 32'd7, 32'd6, 5'd20);
        step();
        set_op(1'b0, 1'b0, 32'd2, 32'd2, 5'd21);
        step();
        bus.multiplierStart = 1'b0;
        step();
        chk("ar_pre_done", 64'(bus.multiplierDone), 64'd1);
        chk("ar_pre_lo", 64'(bus.multiplierResultLow), 64'd42);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_done", 64'(bus.multiplierDone), 64'd0);
        chk("ar_hi", 64'(bus.multiplierResultHigh), 64'd0);
        chk("ar_lo", 64'(bus.multiplierResultLow), 64'd0);
        chk("ar_tag", 64'(bus.tagOut), 64'd0);
        chk("ar_ready", 64'(bus.multiplierReady), 64'd0);
        step();
        reset = 1'b0;
        #1;
        chk("ar_rel_ready", 64'(bus.multiplierReady), 64'd1);
        step();
        chk("ar_discard", 64'(bus.multiplierDone), 64'd0);
        run_one("ar_first", 1'b1, 1'b1, 32'hFFFFFFFE, 32'd3, 5'd22,
                32'hFFFFFFFF, 32'hFFFFFFFA);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
